// File: rtl/inv_sub_bytes_seq_pkg.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq_pkg
// Shared AES constants, controller state encoding and the byte-level GF(2^8)
// helper functions used by the inverse S-box.
// Optional feature macro: INV_SUB_BYTES_ENC_EN (adds the forward affine map).
// -----------------------------------------------------------------------------
package inv_sub_bytes_seq_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTE_W  = 8;

   // Reduction term of x^8 + x^4 + x^3 + x + 1 (0x11B with the x^8 bit dropped)
   localparam logic [7:0] GF_POLY    = 8'h1B;
   localparam logic [7:0] AFF_C_FWD  = 8'h63;
   localparam logic [7:0] AFF_C_INV  = 8'h05;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Carry-less multiply modulo the AES polynomial
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = b[i] ? (p ^ aa) : p;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ GF_POLY) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128); 0 maps to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   // Inverse affine: b = rotl1(a) ^ rotl3(a) ^ rotl6(a) ^ 0x05
   function automatic logic [7:0] inv_affine(input logic [7:0] a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ AFF_C_INV;
   endfunction

`ifdef INV_SUB_BYTES_ENC_EN
   // Forward affine: b = a ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
   function automatic logic [7:0] fwd_affine(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
               ^ {a[3:0], a[7:4]} ^ AFF_C_FWD;
   endfunction
`endif

endpackage

// File: rtl/inv_sub_bytes_seq_inv_sbox.sv
// -----------------------------------------------------------------------------
// inv_sbox
// Combinational AES inverse S-box: inverse affine map, then GF(2^8) inverse.
// Optional feature macro: INV_SUB_BYTES_ENC_EN -- adds the mode input; mode=1
// gives the forward S-box (GF inverse then forward affine) reusing the same
// GF-inverse logic.
// Ports:
//   in_byte  [7:0] byte to substitute
//   mode           (only with INV_SUB_BYTES_ENC_EN) 1 = forward, 0 = inverse
//   out_byte [7:0] substituted byte
// -----------------------------------------------------------------------------
module inv_sbox
   import inv_sub_bytes_seq_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] in_byte,
`ifdef INV_SUB_BYTES_ENC_EN
   input  logic                  mode,
`endif
   output logic [AES_BYTE_W-1:0] out_byte
);

   logic [7:0] gf_in_s;
   logic [7:0] gf_out_s;

`ifdef INV_SUB_BYTES_ENC_EN
   // Single GF inverse; the affine maps sit on either side depending on mode
   always_comb begin
      gf_in_s  = mode ? in_byte : inv_affine(in_byte);
      gf_out_s = gf_inv(gf_in_s);
      out_byte = mode ? fwd_affine(gf_out_s) : gf_out_s;
   end
`else
   // Inverse-only datapath
   always_comb begin
      gf_in_s  = inv_affine(in_byte);
      gf_out_s = gf_inv(gf_in_s);
      out_byte = gf_out_s;
   end
`endif

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq
// Sequential InvSubBytes stage: substitutes BYTES_PER_CYCLE bytes of a captured
// 128-bit state per cycle through shared S-boxes, MSB byte group first.
// Optional feature macro: INV_SUB_BYTES_ENC_EN (adds mode input, forward S-box).
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_valid/ready  upstream handshake; in_data is the state, byte S(r,c) at
//                   in_data[127-8*(4c+r) -: 8]
//   mode            (only with INV_SUB_BYTES_ENC_EN) 1 = SubBytes, 0 = InvSubBytes
//   out_valid/ready downstream handshake; out_data same byte layout
// -----------------------------------------------------------------------------
module inv_sub_bytes_seq
   import inv_sub_bytes_seq_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_data,
`ifdef INV_SUB_BYTES_ENC_EN
   input  logic                   mode,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_data
);

   localparam int N       = 16 / BYTES_PER_CYCLE;
   localparam int GRP_W   = (N > 1) ? $clog2(N) : 1;
   localparam int SLICE_W = AES_BYTE_W * BYTES_PER_CYCLE;
   localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(N - 1);

   generate
      if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
            BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
         $fatal(1, "inv_sub_bytes_seq: illegal BYTES_PER_CYCLE=%0d", BYTES_PER_CYCLE);
      end
   endgenerate

   state_e                 state_q, state_d;
   logic [GRP_W-1:0]       grp_q, grp_d;
   logic [AES_STATE_W-1:0] work_q, work_d;
   logic [AES_STATE_W-1:0] out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;
   logic                   in_ready_q, in_ready_d;
`ifdef INV_SUB_BYTES_ENC_EN
   logic                   mode_q, mode_d;
`endif

   logic [SLICE_W-1:0]     sub_in_s;
   logic [SLICE_W-1:0]     sub_out_s;
   logic [AES_STATE_W-1:0] work_sub_s;

   // Pick the byte group addressed by grp (group 0 = most significant bytes)
   always_comb begin
      sub_in_s = {SLICE_W{1'b0}};
      for (int g = 0; g < N; g++) begin
         sub_in_s = sub_in_s | ((grp_q == GRP_W'(g)) ?
                                work_q[AES_STATE_W-1-SLICE_W*g -: SLICE_W] :
                                {SLICE_W{1'b0}});
      end
   end

   generate
      for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
         inv_sbox u_sbox (
            .in_byte  (sub_in_s[SLICE_W-1-AES_BYTE_W*b -: AES_BYTE_W]),
`ifdef INV_SUB_BYTES_ENC_EN
            .mode     (mode_q),
`endif
            .out_byte (sub_out_s[SLICE_W-1-AES_BYTE_W*b -: AES_BYTE_W])
         );
      end
   endgenerate

   // Work register with the current group replaced by its substituted bytes
   always_comb begin
      work_sub_s = work_q;
      for (int g = 0; g < N; g++) begin
         work_sub_s[AES_STATE_W-1-SLICE_W*g -: SLICE_W] =
            (grp_q == GRP_W'(g)) ? sub_out_s : work_q[AES_STATE_W-1-SLICE_W*g -: SLICE_W];
      end
   end

   // Controller next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      grp_d       = grp_q;
      work_d      = work_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
`ifdef INV_SUB_BYTES_ENC_EN
      mode_d      = mode_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               work_d  = in_data;
               grp_d   = {GRP_W{1'b0}};
               state_d = ST_BUSY;
`ifdef INV_SUB_BYTES_ENC_EN
               mode_d  = mode;
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            work_d = work_sub_s;
            if (grp_q == GRP_LAST) begin
               // Last group: publish the fully substituted state directly
               grp_d       = {GRP_W{1'b0}};
               out_data_d  = work_sub_s;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               grp_d = grp_q + GRP_W'(1);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      // Registered ready: high exactly while the next state is IDLE
      in_ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grp_q       <= {GRP_W{1'b0}};
         work_q      <= {AES_STATE_W{1'b0}};
         out_data_q  <= {AES_STATE_W{1'b0}};
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
`ifdef INV_SUB_BYTES_ENC_EN
         mode_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grp_q       <= grp_d;
         work_q      <= work_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
`ifdef INV_SUB_BYTES_ENC_EN
         mode_q      <= mode_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_sub_bytes_seq
// Directed bench: five instances (BYTES_PER_CYCLE = 4, 1, 2, 8, 16) share clk
// and reset. A vector table covers substitution values and latency; hand
// sequences cover backpressure, reset during BUSY and (with
// INV_SUB_BYTES_ENC_EN) the forward mode.
// -----------------------------------------------------------------------------
module tb_inv_sub_bytes_seq;

   localparam int NDUT = 5;

   logic             clk;
   logic             reset;
   logic [NDUT-1:0]  in_valid_v;
   logic [NDUT-1:0]  in_ready_v;
   logic [NDUT-1:0]  out_valid_v;
   logic [NDUT-1:0]  out_ready_v;
   logic [127:0]     in_data_v  [NDUT];
   logic [127:0]     out_data_v [NDUT];
`ifdef INV_SUB_BYTES_ENC_EN
   logic [NDUT-1:0]  mode_v;
`endif

   int errors;
   int checks;

   typedef struct {
      int           idx;
      logic [127:0] din;
      logic [127:0] dexp;
      int           lat;
   } vec_t;

   vec_t vecs [8];

   localparam logic [127:0] V_FWD = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] V_INV = 128'h000102030405060708090a0b0c0d0e0f;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   generate
      for (genvar i = 0; i < NDUT; i++) begin : g_dut
         localparam int BPC_I = (i == 0) ? 4 : (i == 1) ? 1 : (i == 2) ? 2 : (i == 3) ? 8 : 16;
         inv_sub_bytes_seq #(.BYTES_PER_CYCLE(BPC_I)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid_v[i]),
            .in_ready  (in_ready_v[i]),
            .in_data   (in_data_v[i]),
`ifdef INV_SUB_BYTES_ENC_EN
            .mode      (mode_v[i]),
`endif
            .out_valid (out_valid_v[i]),
            .out_ready (out_ready_v[i]),
            .out_data  (out_data_v[i])
         );
      end
   endgenerate

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Full transaction on one instance: accept, measure latency, check, drain
   task automatic run_block(input int idx, input logic [127:0] din,
                            input logic [127:0] dexp, input int lat_exp, input string name);
      int lat;
      @(negedge clk);
      chk({name, "_ready_before"}, 128'(in_ready_v[idx]), 128'd1);
      in_valid_v[idx] = 1'b1;
      in_data_v[idx]  = din;
      @(posedge clk);
      #1;
      in_valid_v[idx] = 1'b0;
      in_data_v[idx]  = ~din;
      lat = 0;
      while (out_valid_v[idx] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "_latency"}, 128'(lat), 128'(lat_exp));
      chk({name, "_data"}, out_data_v[idx], dexp);
      out_ready_v[idx] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_v[idx] = 1'b0;
      chk({name, "_valid_drop"}, 128'(out_valid_v[idx]), 128'd0);
      chk({name, "_ready_after"}, 128'(in_ready_v[idx]), 128'd1);
   endtask

   initial begin
      int lat;
      errors = 0;
      checks = 0;

      vecs[0] = '{0, 128'h0, {16{8'h52}}, 4};
      vecs[1] = '{0, V_FWD, V_INV, 4};
      vecs[2] = '{1, V_FWD, V_INV, 16};
      vecs[3] = '{2, V_FWD, V_INV, 8};
      vecs[4] = '{3, V_FWD, V_INV, 2};
      vecs[5] = '{4, V_FWD, V_INV, 1};
      vecs[6] = '{0, {8'hff, 112'h0, 8'hed}, {8'h7d, {14{8'h52}}, 8'h53}, 4};
      vecs[7] = '{4, {16{8'h63}}, 128'h0, 1};

      reset       = 1'b1;
      in_valid_v  = '0;
      out_ready_v = '0;
`ifdef INV_SUB_BYTES_ENC_EN
      mode_v      = '0;
`endif
      for (int i = 0; i < NDUT; i++) in_data_v[i] = 128'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state of every instance
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("rst%0d_in_ready", i), 128'(in_ready_v[i]), 128'd1);
         chk($sformatf("rst%0d_out_valid", i), 128'(out_valid_v[i]), 128'd0);
         chk($sformatf("rst%0d_out_data", i), out_data_v[i], 128'h0);
      end

      // Vector table
      for (int v = 0; v < 8; v++) begin
         run_block(vecs[v].idx, vecs[v].din, vecs[v].dexp, vecs[v].lat, $sformatf("vec%0d", v));
      end

      // Backpressure: hold DONE for 10 cycles while a new in_valid is offered
      @(negedge clk);
      in_valid_v[0] = 1'b1;
      in_data_v[0]  = V_FWD;
      @(posedge clk);
      #1;
      in_valid_v[0] = 1'b0;
      lat = 0;
      while (out_valid_v[0] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("bp_latency", 128'(lat), 128'd4);
      for (int k = 0; k < 10; k++) begin
         in_valid_v[0] = 1'b1;
         in_data_v[0]  = 128'h0;
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_out_valid", k), 128'(out_valid_v[0]), 128'd1);
         chk($sformatf("bp%0d_out_data", k), out_data_v[0], V_INV);
         chk($sformatf("bp%0d_in_ready", k), 128'(in_ready_v[0]), 128'd0);
      end
      in_valid_v[0]  = 1'b0;
      out_ready_v[0] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_v[0] = 1'b0;
      chk("bp_release_valid", 128'(out_valid_v[0]), 128'd0);
      chk("bp_release_ready", 128'(in_ready_v[0]), 128'd1);
      chk("bp_release_data_held", out_data_v[0], V_INV);
      run_block(0, V_FWD, V_INV, 4, "bp_next");

      // Reset asserted during the second BUSY cycle
      @(negedge clk);
      in_valid_v[0] = 1'b1;
      in_data_v[0]  = V_FWD;
      @(posedge clk);
      #1;
      in_valid_v[0] = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mid_rst_in_ready", 128'(in_ready_v[0]), 128'd1);
      chk("mid_rst_out_valid", 128'(out_valid_v[0]), 128'd0);
      chk("mid_rst_out_data", out_data_v[0], 128'h0);
      repeat (6) @(posedge clk);
      #1;
      chk("mid_rst_no_output", 128'(out_valid_v[0]), 128'd0);
      run_block(0, {16{8'h63}}, 128'h0, 4, "post_rst");

`ifdef INV_SUB_BYTES_ENC_EN
      // Forward SubBytes through the shared GF inverse
      mode_v[0] = 1'b1;
      run_block(0, V_INV, V_FWD, 4, "enc_mode");
      mode_v[0] = 1'b0;
      run_block(0, V_FWD, V_INV, 4, "dec_after_enc");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
